// File: rtl/fifo_pkg.sv
// fifo_pkg: FSM state type and default geometry shared by the fifo_ctrl slice.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } fifo_state_t;

    localparam int DEFAULT_ADDR_WIDTH     = 3;
    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_ALMOST_FULL_TH = 6;

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and fill-level controller for a FIFO that writes one entry and pops two.
// Defining FIFO_CTRL_ALMOST_EN adds the registered almost_full output.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int ALMOST_FULL_TH = DEFAULT_ALMOST_FULL_TH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic                  rinc,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wfull,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic                  almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0]   FILL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   FILL_TWO   = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]   FILL_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TWO   = ADDR_WIDTH'(2);

    fifo_state_t           r_state;
    fifo_state_t           w_stateNext;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [ADDR_WIDTH-1:0] r_rdAddr;
    logic [ADDR_WIDTH:0]   r_fill;
    logic [ADDR_WIDTH:0]   w_fillNext;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wrAcc;
    logic                  w_rdAcc;
    logic                  w_flushReq;
    logic                  w_holdErr;
    logic                  w_ovfEvent;
    logic                  w_unfEvent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Status flags come only from registered state; INIT and FLUSH report both full and empty.
    always_comb begin
        w_stateNext = r_state;
        w_full      = 1'b1;
        w_empty     = 1'b1;
        w_wrAcc     = 1'b0;
        w_rdAcc     = 1'b0;
        w_flushReq  = 1'b0;
        w_holdErr   = 1'b0;
        w_ovfEvent  = 1'b0;
        w_unfEvent  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                w_full  = (r_fill == FILL_DEPTH);
                w_empty = (r_fill < FILL_TWO);
                if (flush) begin
                    w_stateNext = ST_FLUSH;
                    w_flushReq  = 1'b1;
                    w_holdErr   = 1'b1;
                end else begin
                    w_wrAcc    = winc && !w_full;
                    w_rdAcc    = rinc && !w_empty;
                    w_ovfEvent = winc && w_full;
                    w_unfEvent = rinc && w_empty;
                end
            end
            ST_FLUSH: begin
                w_stateNext = ST_RUN;
                w_holdErr   = 1'b1;
            end
            default: begin
                w_stateNext = ST_INIT;
            end
        endcase
    end

    always_comb begin
        w_fillNext = r_fill;
        if (w_flushReq) begin
            w_fillNext = '0;
        end else begin
            case ({w_wrAcc, w_rdAcc})
                2'b10:   w_fillNext = r_fill + FILL_ONE;
                2'b01:   w_fillNext = r_fill - FILL_TWO;
                2'b11:   w_fillNext = r_fill - FILL_ONE;
                default: w_fillNext = r_fill;
            endcase
        end
    end

    // Depth is a power of two, so pointer wrap is the natural roll-over of the address width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrAddr <= '0;
            r_rdAddr <= '0;
            r_fill   <= '0;
        end else begin
            r_fill <= w_fillNext;
            if (w_flushReq) begin
                r_wrAddr <= '0;
                r_rdAddr <= '0;
            end else begin
                if (w_wrAcc) begin
                    r_wrAddr <= r_wrAddr + ADDR_ONE;
                end
                if (w_rdAcc) begin
                    r_rdAddr <= r_rdAddr + ADDR_TWO;
                end
            end
        end
    end

    // A new error event beats a same-cycle clear; flushing freezes both flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!w_holdErr) begin
            r_overflow  <= (r_overflow  && !clear_err) || w_ovfEvent;
            r_underflow <= (r_underflow && !clear_err) || w_unfEvent;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] FILL_AF = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);

    logic r_almostFull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_almostFull <= 1'b0;
        end else begin
            r_almostFull <= (w_fillNext >= FILL_AF);
        end
    end

    assign almost_full = r_almostFull;
`endif

    assign wr_addr    = r_wrAddr;
    assign rd_addr    = r_rdAddr;
    assign fill_level = r_fill;
    assign wfull      = w_full;
    assign rempty     = w_empty;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and random stimulus for fifo_ctrl checked against a counter-level model.
// Define FIFO_CTRL_ALMOST_EN to also check almost_full.
module tb_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int TH    = 6;

    localparam int MODE_INIT  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_FLUSH = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          winc      = 1'b0;
    logic          rinc      = 1'b0;
    logic          flush     = 1'b0;
    logic          clear_err = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wfull;
    logic          rempty;
    logic [AW:0]   fill_level;
    logic          overflow;
    logic          underflow;
`ifdef FIFO_CTRL_ALMOST_EN
    logic          almost_full;
`endif

    int checkCount = 0;
    int passCount  = 0;

    int mMode;
    int mCount;
    int mWr;
    int mRd;
    bit mOvf;
    bit mUnf;

    fifo_ctrl #(
        .ADDR_WIDTH    (AW),
        .FIFO_DEPTH    (DEPTH),
        .ALMOST_FULL_TH(TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .winc       (winc),
        .rinc       (rinc),
        .flush      (flush),
        .clear_err  (clear_err),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .wfull      (wfull),
        .rempty     (rempty),
        .fill_level (fill_level),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic modelReset();
        mMode  = MODE_INIT;
        mCount = 0;
        mWr    = 0;
        mRd    = 0;
        mOvf   = 1'b0;
        mUnf   = 1'b0;
    endtask

    // Controller behaviour in terms of entry counts and pointer positions.
    task automatic modelStep(input bit w, input bit r, input bit f, input bit c);
        bit full;
        bit empty;
        bit wa;
        bit ra;
        if (mMode == MODE_INIT) begin
            mMode = MODE_RUN;
            mOvf  = mOvf && !c;
            mUnf  = mUnf && !c;
        end else if (mMode == MODE_FLUSH) begin
            mMode = MODE_RUN;
        end else if (f) begin
            mMode  = MODE_FLUSH;
            mCount = 0;
            mWr    = 0;
            mRd    = 0;
        end else begin
            full   = (mCount == DEPTH);
            empty  = (mCount < 2);
            wa     = w && !full;
            ra     = r && !empty;
            mCount = mCount + (wa ? 1 : 0) - (ra ? 2 : 0);
            mWr    = (mWr + (wa ? 1 : 0)) % DEPTH;
            mRd    = (mRd + (ra ? 2 : 0)) % DEPTH;
            mOvf   = (mOvf && !c) || (w && full);
            mUnf   = (mUnf && !c) || (r && empty);
        end
    endtask

    task automatic checkAll(input string ctx);
        checkOutput({ctx, ".wr_addr"},    32'(wr_addr),    32'(mWr));
        checkOutput({ctx, ".rd_addr"},    32'(rd_addr),    32'(mRd));
        checkOutput({ctx, ".fill_level"}, 32'(fill_level), 32'(mCount));
        checkOutput({ctx, ".wfull"},      32'(wfull),      32'((mMode != MODE_RUN) || (mCount == DEPTH)));
        checkOutput({ctx, ".rempty"},     32'(rempty),     32'((mMode != MODE_RUN) || (mCount < 2)));
        checkOutput({ctx, ".overflow"},   32'(overflow),   32'(mOvf));
        checkOutput({ctx, ".underflow"},  32'(underflow),  32'(mUnf));
`ifdef FIFO_CTRL_ALMOST_EN
        checkOutput({ctx, ".almost_full"}, 32'(almost_full), 32'(mCount >= TH));
`endif
    endtask

    task automatic applyStimulus(input bit w, input bit r, input bit f, input bit c, input string ctx);
        winc      = w;
        rinc      = r;
        flush     = f;
        clear_err = c;
        @(posedge clk);
        modelStep(w, r, f, c);
        #1;
        checkAll(ctx);
    endtask

    initial begin
        bit rw;
        bit rr;
        bit rf;
        bit rc;

        rst = 1'b1;
        #12;
        modelReset();
        checkAll("reset");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "initToRun");
        checkOutput("initToRun.literal.rempty", 32'(rempty), 32'd1);
        checkOutput("initToRun.literal.wfull", 32'(wfull), 32'd0);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "fill");
        checkOutput("fill.literal.wr_addr", 32'(wr_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "overflow");
        checkOutput("overflow.literal", 32'(overflow), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "clearVsEvent");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "fullReadBlocksWrite");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "clearErr");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "flushCycle");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "afterFlush");

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "oneWrite");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "underflow");
        checkOutput("underflow.literal", 32'(underflow), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "secondWrite");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "pairRead");
        checkOutput("pairRead.literal.rd_addr", 32'(rd_addr), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "clearUnderflow");

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "toFour");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "writeAndRead");
        checkOutput("writeAndRead.literal.fill", 32'(fill_level), 32'd3);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "toFive");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "flushWithWrite");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "afterFlush5");

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "refill");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "flushWhenFull");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "flushBackToRun");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "flushWhenEmpty");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "underflowAgain");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "flushHoldsErr");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "flushStateHoldsErr");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "clearAfterFlush");

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "preReset");
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("asyncReset");
        #3;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "initIgnoresRequests");

        for (int n = 0; n < 400; n++) begin
            rw = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < 40);
            rf = ($urandom_range(0, 99) < 3);
            rc = ($urandom_range(0, 99) < 6);
            applyStimulus(rw, rr, rf, rc, "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, memory address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count; equals 2**ADDR_WIDTH and is even.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 6, fill level at which almost_full asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port winc  input  1  write request from producer.
REQ-007 SHALL have port rinc  input  1  read request from consumer; one read pops two entries.
REQ-008 SHALL have port flush  input  1  synchronous request to discard all contents.
REQ-009 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-010 SHALL have port wr_addr  output  ADDR_WIDTH  memory write address.
REQ-011 SHALL have port rd_addr  output  ADDR_WIDTH  memory read address (lower entry of pair).
REQ-012 SHALL have port wfull  output  1  no write is accepted this cycle.
REQ-013 SHALL have port rempty  output  1  fewer than two entries held; no read is accepted.
REQ-014 SHALL have port fill_level  output  ADDR_WIDTH+1  entries currently held, 0..FIFO_DEPTH.
REQ-015 SHALL have port overflow  output  1  sticky: winc seen while wfull.
REQ-016 SHALL have port underflow  output  1  sticky: rinc seen while rempty.
REQ-017 SHALL have port almost_full  output  1  present only with FIFO_CTRL_ALMOST_EN.

Function
REQ-018 SHALL implement FSM states INIT, RUN, FLUSH; reset enters INIT.
REQ-019 SHALL move INIT->RUN unconditionally on the first clock edge after reset release; INIT forces wfull=1 and rempty=1.
REQ-020 SHALL move RUN->FLUSH when flush=1; FLUSH lasts exactly one cycle, zeroes wr_addr, rd_addr and fill_level, forces wfull=1 and rempty=1, then returns to RUN.
REQ-021 SHALL accept a write in RUN when winc=1 and wfull=0; wr_addr then advances by 1 modulo FIFO_DEPTH.
REQ-022 SHALL accept a read in RUN when rinc=1 and rempty=0; rd_addr then advances by 2 modulo FIFO_DEPTH, so rd_addr is always even.
REQ-023 SHALL update fill_level by +1 for an accepted write, -2 for an accepted read, and -1 when both are accepted in the same cycle.
REQ-024 SHALL drive wfull = (fill_level == FIFO_DEPTH) and rempty = (fill_level < 2) in RUN, decoded from registered state only, with no combinational path from winc or rinc.
REQ-025 SHALL block a write when full, even if a read is accepted in the same cycle.
REQ-026 SHALL give flush priority over any same-cycle winc or rinc; neither is accepted and neither sets an error flag.
REQ-027 SHALL set overflow on winc=1 with wfull=1 in RUN, and set underflow on rinc=1 with rempty=1 in RUN; both hold until clear_err.
REQ-028 SHALL, when clear_err and a new error event occur in the same cycle, leave that flag set.
REQ-029 SHALL not alter error flags during a flush.

Reset
REQ-030 SHALL, on rst=1 and independent of clk, drive wr_addr=0, rd_addr=0, fill_level=0, overflow=0, underflow=0, almost_full=0, state=INIT, wfull=1 and rempty=1.

Configuration
REQ-031 SHALL, with macro FIFO_CTRL_ALMOST_EN defined, include the almost_full port, registered as (next fill_level >= ALMOST_FULL_TH).
REQ-032 SHALL, with FIFO_CTRL_ALMOST_EN undefined, omit the almost_full port and its logic entirely.

Structure
REQ-033 SHALL place the FSM state enum type and the default-depth constants in shared package fifo_pkg.
REQ-034 SHALL be a single module with no sub-modules; it drives the external dual-read FIFO memory through wr_addr, rd_addr, wfull and rempty.

Verification
REQ-035 SHALL cover: reset, then one clock -> INIT then RUN; fill_level=0, wfull=0, rempty=1.
REQ-036 SHALL cover: 8 writes, then one more winc -> fill_level=8, wfull=1, wr_addr=0 (wrapped), overflow=1.
REQ-037 SHALL cover: one write, then rinc -> read not accepted, underflow=1, rd_addr=0; a second write then rinc -> rd_addr=2, fill_level=0.
REQ-038 SHALL cover: fill_level=4 with winc=rinc=1 -> fill_level=3, wr_addr+1, rd_addr+2.
REQ-039 SHALL cover: fill_level=5 with flush=winc=1 -> one FLUSH cycle with wfull=1; then fill_level=0, addresses 0, no overflow.
REQ-040 SHALL cover: with FIFO_CTRL_ALMOST_EN, the 6th write -> almost_full=1 on the same edge that fill_level becomes 6.
